// File: rtl/kbd_event_queue.sv
// PS/2 keyboard receiver, scan-code decoder (E0/F0 prefixes) and event FIFO.
// Optional typematic repeat suppression is enabled by defining KBD_REPEAT_FILTER_EN.
module kbd_event_queue #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        en,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_brk,
  output logic [31:0]                 cur_key,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       ps2_fall;
  logic       rx_bit;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[1];
  assign rx_bit   = data_sync[1];

  // ---------------------------------------------------------------------------
  // Frame receiver: start, 8 data LSB first, odd parity, stop
  // ---------------------------------------------------------------------------
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic [10:0]   frame;
  logic          frame_ok;
  logic          byte_valid;
  logic [7:0]    byte_data;

  // Ten bits are already shifted in when the stop bit arrives on rx_bit.
  assign frame    = {rx_bit, shreg};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      if (ps2_fall) begin
        idle_cnt <= '0;
        shreg    <= {rx_bit, shreg[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= frame[8:1];
          end else begin
            parity_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is silently abandoned.
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code decoder FSM
  // ---------------------------------------------------------------------------
  dec_state_t state, state_nx;
  logic       is_prefix;
  logic       emit_raw;
  logic       ext_flag;
  logic       brk_flag;
  logic       suppress;
  logic       emit;

  assign is_prefix = ((byte_data == CODE_EXT) && (state == S_IDLE)) ||
                     ((byte_data == CODE_BRK) && ((state == S_IDLE) || (state == S_EXT)));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (byte_valid) begin
      if (!is_prefix)                                     state_nx = S_IDLE;
      else if (byte_data == CODE_EXT)                     state_nx = S_EXT;
      else if (state == S_IDLE)                           state_nx = S_BRK;
      else                                                state_nx = S_EXT_BRK;
    end
  end

  always_comb begin
    emit_raw = byte_valid & ~is_prefix;
    ext_flag = (state == S_EXT) || (state == S_EXT_BRK);
    brk_flag = (state == S_BRK) || (state == S_EXT_BRK);
  end

`ifdef KBD_REPEAT_FILTER_EN
  // Tracks the last queued make so typematic repeats of it can be dropped.
  logic       rpt_valid;
  logic [8:0] rpt_key;

  assign suppress = emit_raw & ~brk_flag & rpt_valid & (rpt_key == {ext_flag, byte_data});

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_valid <= 1'b0;
      rpt_key   <= '0;
    end else if (emit_raw) begin
      if (brk_flag) begin
        if (rpt_key == {ext_flag, byte_data}) rpt_valid <= 1'b0;
      end else if (en && !suppress) begin
        rpt_valid <= 1'b1;
        rpt_key   <= {ext_flag, byte_data};
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign emit = emit_raw & ~suppress;

  // ---------------------------------------------------------------------------
  // Event register: cur_key and the queue write both land one cycle later
  // ---------------------------------------------------------------------------
  logic       ev_push;
  kbd_event_t ev_word;
  logic [31:0] key_packed;

  always_comb begin
    key_packed = {24'h0, byte_data};
    case ({ext_flag, brk_flag})
      2'b01:   key_packed = {16'h0, CODE_BRK, byte_data};
      2'b10:   key_packed = {16'h0, CODE_EXT, byte_data};
      2'b11:   key_packed = {8'h0, CODE_EXT, CODE_BRK, byte_data};
      default: key_packed = {24'h0, byte_data};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_push <= 1'b0;
      ev_word <= '0;
      cur_key <= '0;
    end else begin
      ev_push <= emit & en;
      if (emit) begin
        ev_word <= {ext_flag, brk_flag, byte_data};
        cur_key <= key_packed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  kbd_event_t     mem [FIFO_DEPTH];
  kbd_event_t     head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           do_push;
  logic           do_pop;

  // Full is judged on the pre-pop occupancy, so a push into a full queue
  // is dropped even when a pop happens in the same cycle.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = ev_push & ~full;
  assign do_pop  = ev_valid & ev_ready;

  // NOTE: the storage array has no reset; only pointers and count define
  // validity, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ev_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                overflow <= 1'b0;
    else if (ev_push && full) overflow <= 1'b1;
    else if (ovf_clr)         overflow <= 1'b0;
  end

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_brk     = head.brk;
  assign fifo_count = count;

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue: table of single frames plus multi-cycle
// sequences for reset, overflow, timeout and repeat handling.
module tb_kbd_event_queue;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic        en;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  ev_code;
  logic        ev_ext;
  logic        ev_brk;
  logic [31:0] cur_key;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr;
  logic        parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  int perr_cnt = 0;

  kbd_event_queue #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .en         (en),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_brk     (ev_brk),
    .cur_key    (cur_key),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (parity_err) perr_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  code;
    bit          good;
    bit          en;
    logic [31:0] exp_key;
    int          exp_count;
    int          exp_perr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sends the first nbits bits of a frame, then leaves the line idle for HALF cycles.
  task automatic send_bits(input logic [7:0] b, input bit good, input int nbits);
    logic [10:0] f;
    logic        p;
    p = good ? ~(^b) : (^b);
    f = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic ext, input logic brk, input logic [7:0] code);
    check({name, "_valid"}, {31'h0, ev_valid}, 32'h1);
    check(name, {22'h0, ev_ext, ev_brk, ev_code}, {22'h0, ext, brk, code});
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0]  ovf_codes [10];
  logic [31:0] prev_key;
  bit          seen;
  int          exp_rpt;

  initial begin
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 32'h0000_001C, 1, 0};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 32'h0000_001C, 1, 0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 32'h0000_F01C, 2, 0};
    vecs[3] = '{8'hE0, 1'b1, 1'b1, 32'h0000_F01C, 2, 0};
    vecs[4] = '{8'hF0, 1'b1, 1'b1, 32'h0000_F01C, 2, 0};
    vecs[5] = '{8'h75, 1'b1, 1'b1, 32'h00E0_F075, 3, 0};
    vecs[6] = '{8'hE0, 1'b1, 1'b1, 32'h00E0_F075, 3, 0};
    vecs[7] = '{8'h12, 1'b0, 1'b1, 32'h00E0_F075, 3, 1};
    vecs[8] = '{8'h74, 1'b1, 1'b1, 32'h0000_E074, 4, 0};
    vecs[9] = '{8'h33, 1'b1, 1'b0, 32'h0000_0033, 4, 0};

    ovf_codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4B};

    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    en       = 1'b1;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    do_reset();

    check("rst_cur_key",  cur_key, 32'h0);
    check("rst_count",    {28'h0, fifo_count}, 32'h0);
    check("rst_ev_valid", {31'h0, ev_valid}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_perr",     {31'h0, parity_err}, 32'h0);

    // Table: one frame per entry, consumer stalled.
    for (int i = 0; i < 10; i++) begin
      en       = vecs[i].en;
      perr_cnt = 0;
      send_bits(vecs[i].code, vecs[i].good, 11);
      check($sformatf("vec%0d_cur_key", i), cur_key, vecs[i].exp_key);
      check($sformatf("vec%0d_count", i), {28'h0, fifo_count}, 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_perr", i), 32'(perr_cnt), 32'(vecs[i].exp_perr));
    end
    en = 1'b1;

    pop_check("tbl_pop0", 1'b0, 1'b0, 8'h1C);
    pop_check("tbl_pop1", 1'b0, 1'b1, 8'h1C);
    pop_check("tbl_pop2", 1'b1, 1'b1, 8'h75);
    pop_check("tbl_pop3", 1'b1, 1'b0, 8'h74);
    check("tbl_empty", {28'h0, fifo_count}, 32'h0);

    // Reset mid-frame: the partial bits must not corrupt the next frame.
    send_bits(8'h5A, 1'b1, 5);
    do_reset();
    check("midrst_count", {28'h0, fifo_count}, 32'h0);
    send_bits(8'h1C, 1'b1, 11);
    check("midrst_ev_count", {28'h0, fifo_count}, 32'h1);
    pop_check("midrst_pop", 1'b0, 1'b0, 8'h1C);

    // Overflow: nine makes into an eight-deep queue.
    for (int i = 0; i < 9; i++) send_bits(ovf_codes[i], 1'b1, 11);
    check("ovf_count", {28'h0, fifo_count}, 32'd8);
    check("ovf_flag",  {31'h0, overflow}, 32'h1);
    check("ovf_head",  {24'h0, ev_code}, {24'h0, ovf_codes[0]});
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Push into a full queue with a pop in the same cycle: still dropped.
    prev_key = cur_key;
    seen     = 1'b0;
    fork
      send_bits(ovf_codes[9], 1'b1, 11);
      begin
        for (int c = 0; c < 1000 && !seen; c++) begin
          @(negedge clk);
          if (cur_key != prev_key) begin
            seen     = 1'b1;
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
          end
        end
      end
    join
    check("fullpop_seen",  {31'h0, seen}, 32'h1);
    check("fullpop_count", {28'h0, fifo_count}, 32'd7);
    check("fullpop_ovf",   {31'h0, overflow}, 32'h1);
    for (int i = 1; i < 8; i++) pop_check($sformatf("ovf_pop%0d", i), 1'b0, 1'b0, ovf_codes[i]);
    check("ovf_drained", {28'h0, fifo_count}, 32'h0);

    // Timeout: four bits, a long gap, then a clean frame.
    perr_cnt = 0;
    send_bits(8'h1C, 1'b1, 4);
    repeat (TIMEOUT + 100) @(negedge clk);
    send_bits(8'h1C, 1'b1, 11);
    check("tmo_count", {28'h0, fifo_count}, 32'h1);
    check("tmo_perr",  32'(perr_cnt), 32'h0);
    pop_check("tmo_pop", 1'b0, 1'b0, 8'h1C);

    // Typematic repeats of the same make.
`ifdef KBD_REPEAT_FILTER_EN
    exp_rpt = 1;
`else
    exp_rpt = 3;
`endif
    for (int i = 0; i < 3; i++) send_bits(8'h29, 1'b1, 11);
    check("rpt_count", {28'h0, fifo_count}, 32'(exp_rpt));
    check("rpt_cur_key", cur_key, 32'h0000_0029);
    pop_check("rpt_pop", 1'b0, 1'b0, 8'h29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
